bit8_to_trit5: RTL
==================

// Module: bit8_to_trit5
// PURPOSE
//  Unpacks one 8-bit packed byte into 5 trits, the inverse of the encaps 5-trit->8-bit packer.
//  Sits on the decaps/unpack path between the byte stream and the ternary SIPO.
//  Byte value v = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4, with t_i in {0,1,2}.
//  Digits come from repeated divide-by-3 with remainder.
// PARAMETERS
//  STEPS_PER_CYC  1  div-by-3 steps done per clock; legal values 1 or 5 (5 = one-cycle conversion)
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst_n      in   1   reset, synchronous, active-low
//  byte_in    in   8   packed byte; sampled on the input handshake
//  in_valid   in   1   byte_in valid
//  in_ready   out  1   block can accept a byte
//  trits_out  out  10  {t4,t3,t2,t1,t0}, 2 bits per trit, t0 in [1:0]
//  out_valid  out  1   trits_out/err valid
//  out_ready  in   1   consumer accepts trits_out
//  err        out  1   byte_in > 242 (not a legal 5-trit packing)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; out_valid=0, trits_out=0, err=0, step counter=0.
//    in_ready=0 while rst_n=0; otherwise in_ready = (state==IDLE).
//  - FSM: IDLE -> CONV on in_valid&in_ready (byte latched into quotient reg q, trits cleared).
//    CONV: each edge performs STEPS_PER_CYC steps: t[k] <= q mod 3, q <= q div 3, k++.
//    CONV -> DONE on the edge completing step k=4. DONE: out_valid=1, outputs held stable.
//    DONE -> IDLE on out_valid&out_ready. No new byte is accepted in CONV or DONE.
//  - Latency: out_valid rises 5/STEPS_PER_CYC cycles after the accept edge (5 or 1).
//    Throughput with out_ready tied high: one byte per 5/STEPS_PER_CYC+2 cycles.
//  - Trit encoding: 0->2'b00, 1->2'b01, 2->2'b10; 2'b11 is never produced.
//  - Arithmetic: q is 8 bits; mod/div by 3 is combinational per step, no wider intermediates.
//  - Out-of-range byte (243..255): trits are the digits of (v mod 243); err=1 when the residual
//    quotient after step 4 is nonzero. err is valid only with out_valid.
//  - in_valid while busy: ignored, byte_in is not sampled; source must hold until in_ready.
//  - out_ready while out_valid=0: no effect.
//  - Backpressure: trits_out and err are stable while out_valid=1 and out_ready=0.
//  - Reset mid-CONV or in DONE: conversion aborted, no output is produced, outputs are
//    returned to reset values.
// CONFIGURATION
//  TRIT5_SIGNED_EN defined: trits emitted as balanced {-1,0,+1}: 0->00, +1->01, -1 (digit 2)->11.
//    Packing arithmetic is unchanged; only the 2-bit code for digit 2 differs.
//  TRIT5_SIGNED_EN undefined: unsigned {0,1,2} encoding as above.
// TESTING
//  T1 byte 0x00 -> after latency: trits_out=10'h000, err=0; in_ready back high one cycle after handshake.
//  T2 byte 0xF2 (242) -> trits_out=10'h2AA (all 2), err=0; with TRIT5_SIGNED_EN trits_out=10'h3FF.
//  T3 byte 0x05 -> trits_out=10'h006 (t0=2,t1=1), err=0; with STEPS_PER_CYC=5 out_valid rises 1 cycle after accept.
//  T4 byte 0xF3 -> trits_out=10'h000, err=1; byte 0xFF -> trits_out=10'h014, err=1.
//  T5 byte 0x05 with out_ready=0 for 3 cycles after out_valid -> trits_out held at 10'h006.
//     in_valid=1 with byte 0x11 during that hold -> not accepted; 0x11 taken only after out handshake.
//  T6 rst_n=0 on 3rd CONV cycle -> next cycle out_valid=0, trits_out=0, err=0.
//     in_ready=1 once rst_n=1; next byte 0x01 -> trits_out=10'h001.

Source files
------------

// File: rtl/bit8_to_trit5.sv
// bit8_to_trit5: unpacks a byte into five base-3 digits by repeated divide-by-3.
// Define TRIT5_SIGNED_EN to emit digit 2 as balanced -1 (2'b11) instead of 2'b10.
module bit8_to_trit5 #(
  parameter int STEPS_PER_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] trits_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] q_q, q_d, qs;
  logic [9:0] t_q, t_d, ts;
  logic [2:0] k_q, k_d, ks;
  logic err_q, err_d;
  logic [1:0] r;
`ifdef TRIT5_SIGNED_EN
  localparam logic [1:0] TWO = 2'b11;
`else
  localparam logic [1:0] TWO = 2'b10;
`endif
  always_comb begin
    qs = q_q;
    ts = t_q;
    ks = k_q;
    r = '0;
    for (int i = 0; i < STEPS_PER_CYC; i++) begin
      r = 2'(qs % 8'd3);
      ts[{ks, 1'b0} +: 2] = (r == 2'd2) ? TWO : r;
      qs = qs / 8'd3;
      ks = ks + 3'd1;
    end
  end
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    t_d = t_q;
    k_d = k_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = CONV;
        q_d = byte_in;
        t_d = '0;
        k_d = '0;
        err_d = 1'b0;
      end
      CONV: begin
        q_d = qs;
        t_d = ts;
        k_d = ks;
        // a nonzero quotient left after five digits means the byte exceeded 242
        if (ks == 3'd5) begin
          state_d = DONE;
          err_d = qs != 8'd0;
        end
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        k_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q <= '0;
      t_q <= '0;
      k_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      t_q <= t_d;
      k_q <= k_d;
      err_q <= err_d;
    end
  end
  assign in_ready = rst_n && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign trits_out = t_q;
  assign err = err_q;
endmodule
